// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two valid/ready writeback requesters,
// round-robin grant, registered RF write stage, conflict detection and counters.
module rf_write_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              last_grant,
  output logic              conflict,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  conflict_count
);

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;
  logic              conflict_d;

  // Round-robin grant: on a tie, the requester not granted last time wins.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    sel_addr   = req0_addr;
    sel_data   = req0_data;
    if (!hold) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
    if (grant1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
    xfer       = grant0 || grant1;
    sel_we     = xfer && (sel_addr != '0);
    conflict_d = !hold && req0_valid && req1_valid &&
                 (req0_addr == req1_addr) && (req0_addr != '0);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Registered write stage, grant history, conflict pulse and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we          <= 1'b0;
      rf_wa          <= '0;
      rf_wd          <= '0;
      last_grant     <= 1'b1;
      conflict       <= 1'b0;
      wr_count       <= '0;
      conflict_count <= '0;
    end else begin
      rf_we    <= sel_we;
      conflict <= conflict_d;
      if (xfer) begin
        rf_wa      <= sel_addr;
        rf_wd      <= sel_data;
        last_grant <= grant1;
      end
      if (sel_we) begin
        wr_count <= wr_count + CNT_W'(1);
      end
      if (conflict_d) begin
        conflict_count <= conflict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port (write-enable, 5-bit write address, 32-bit write data) between two writeback requesters: req0 for ALU writeback and req1 for the memory/multi-cycle unit. It uses valid/ready handshakes, round-robin arbitration and a registered output stage, so the RF sees exactly one clean write per clock. Writes to register 0 are accepted but suppressed, so the register file never receives them. A hold input lets the control path freeze the write port.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, write data width
CNT_W, 16, width of the accepted-write and conflict counters

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
hold  input  1  freezes arbitration; no grants while high
req0_valid  input  1  requester 0 has a write pending
req0_ready  output  1  requester 0's write is accepted this cycle
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req1_valid  input  1  requester 1 has a write pending
req1_ready  output  1  requester 1's write is accepted this cycle
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
rf_we  output  1  register-file write enable (registered)
rf_wa  output  ADDR_W  register-file write address (registered)
rf_wd  output  DATA_W  register-file write data (registered)
last_grant  output  1  index of the most recently granted requester
conflict  output  1  one-cycle pulse: both requesters valid, same nonzero address
wr_count  output  CNT_W  number of writes issued to the RF (rf_we cycles)
conflict_count  output  CNT_W  number of conflict pulses

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - last_grant=1, so req0 wins the first tie.
  - conflict=0, both counters=0.
  - Any accepted-but-not-yet-issued write is discarded. Requesters must re-present after reset.
- Grant logic (combinational, from current inputs and the last_grant register):
  - hold=1: both readies are 0.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester whose index differs from last_grant is granted.
  - Neither valid: no grant.
  - req_ready is asserted only for the granted requester, and never more than one ready per cycle.
- Handshake:
  - A transfer occurs on the rising edge where valid=1 and ready=1.
  - A requester must hold valid, addr and data stable until it sees ready.
  - ready may depend combinationally on valid.
- Output stage (registered):
  - On the transfer edge: rf_wa and rf_wd load the granted address and data; rf_we loads (addr != 0); last_grant loads the granted index.
  - With no transfer on an edge: rf_we loads 0, and rf_wa/rf_wd hold their values.
  - Latency: accepted at edge N, the RF writes at edge N+1.
  - Throughput: 1 write per cycle. Under sustained contention, grants alternate req0, req1, req0, ...
- Address 0: the write is accepted (ready=1), rf_we stays 0 for it, and last_grant still updates.
- Conflict:
  - Registered pulse, asserted the cycle after an edge where hold=0, both valid, req0_addr==req1_addr and the address is nonzero.
  - The granted write issues first. The loser is granted next cycle, so its data is the final RF value. This ordering is the required architectural behaviour.
- hold:
  - Takes effect on the same cycle: no grant.
  - A write already registered before hold rose still issues on the following edge.
  - last_grant does not change while hold=1.
- Counters:
  - wr_count increments on each edge where rf_we is loaded with 1.
  - conflict_count increments with each conflict pulse.
  - Both wrap modulo 2^CNT_W with no saturation.
- No combinational path from req inputs to rf_* outputs.

Test Plan:
- Reset release, req0 only (addr=5, data=0xDEADBEEF): req0_ready=1 in the same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; wr_count=1, last_grant=0.
- Both valid for 4 cycles (req0 addr=3, data=0x11; req1 addr=4, data=0x22, both held): grant order req0, req1, req0, req1; rf_wa sequence 3, 4, 3, 4 with rf_we=1 every cycle; wr_count=4.
- Both valid, addr=7 for both (req0 data=0xA, req1 data=0xB): conflict pulses once (conflict_count=1); rf_wd=0xA then 0xB on consecutive cycles, so register 7 ends holding 0xB.
- req1 addr=0, data=0xFFFF: req1_ready=1; next cycle rf_we=0; wr_count unchanged; last_grant=1.
- Pending accepted write, then hold=1 for 3 cycles with both valid: the pending write issues, then rf_we=0 and both readies are 0 for the 3 cycles; last_grant is unchanged; grants resume when hold=0.
- rst asserted asynchronously mid-cycle after an accept: rf_we=0 immediately with no RF write; counters=0, last_grant=1.
